// File: rtl/fetch_queue.sv
// fetch_queue: circular FIFO of {pc, pc8, instr} triples between the IFU and the ID stage.
// Define FQ_BYPASS_EN to add a combinational in->out path when the queue is empty.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_pc8,
  input  logic [31:0] in_instr,
  output logic        in_ready,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc8,
  output logic [31:0] out_instr,
  input  logic        out_ready
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [95:0]   mem [DEPTH];
  logic [95:0]   head;
  logic          stored;
  logic          push;
  logic          pop;

  assign stored   = (count != '0);
  assign in_ready = (count != FULL);
  assign head     = mem[rd_ptr];
  assign pop      = stored && out_ready;

`ifdef FQ_BYPASS_EN
  logic bypass;
  logic direct;

  // An empty queue forwards the incoming triple; it is stored only if decode does not take it.
  assign bypass    = !stored && in_valid;
  assign direct    = bypass && out_ready && !flush;
  assign push      = in_valid && in_ready && !direct;
  assign out_valid = stored || bypass;

  always_comb begin
    {out_pc, out_pc8, out_instr} = '0;
    if (stored)
      {out_pc, out_pc8, out_instr} = head;
    else if (bypass)
      {out_pc, out_pc8, out_instr} = {in_pc, in_pc8, in_instr};
  end
`else
  assign push      = in_valid && in_ready;
  assign out_valid = stored;
  assign {out_pc, out_pc8, out_instr} = stored ? head : 96'h0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)
        count <= count + (AW+1)'(1);
      else if (pop && !push)
        count <= count - (AW+1)'(1);
    end
  end

  // Entry storage carries no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push && !flush)
      mem[wr_ptr] <= {in_pc, in_pc8, in_instr};
  end

endmodule
